binary_morph_3x3: RTL

// - Binary morphology stage directly downstream of the 1-bit 3x3 window generator.
// - Consumes the 3x3 binary window (p11..p33) and produces one eroded or dilated pixel per window.
// - Window positions on the frame border are forced to a fixed value.
// - Output feeds the VGA display path in place of the raw Sobel binary image.

---
 rtl/binary_morph_3x3_pkg.sv | 22 ++
 rtl/binary_morph_3x3_if.sv | 24 ++
 rtl/binary_morph_3x3_pos_cnt.sv | 47 ++++
 rtl/binary_morph_3x3.sv | 118 +++++++++++
 4 files changed

// File: rtl/binary_morph_3x3_pkg.sv
// Shared types and constants for the 3x3 binary morphology stage.
package morph_pkg;

  localparam logic MODE_ERODE  = 1'b0;
  localparam logic MODE_DILATE = 1'b1;

  localparam int POS_W    = 16;
  localparam int FG_CNT_W = 32;
  localparam int PIPE_LAT = 2;

  // Stage-1 payload: per-row reductions plus what S2 needs to finish the pixel.
  typedef struct packed {
    logic       border;
    logic       mode;
    logic [2:0] rows;
  } s1_t;

  function automatic logic reduce3(input logic [2:0] v, input logic mode);
    return (mode == MODE_DILATE) ? |v : &v;
  endfunction

endpackage

// File: rtl/binary_morph_3x3_if.sv
// Window-in / pixel-out bundle between the window generator, morphology stage and display path.
interface binary_morph_3x3_if;
  import morph_pkg::*;

  logic                mode;
  logic                win_en;
  logic                p11, p12, p13;
  logic                p21, p22, p23;
  logic                p31, p32, p33;
  logic                morph_en;
  logic                morph_data;
  logic [FG_CNT_W-1:0] fg_count;
  logic                fg_valid;

  modport master (
    output mode, win_en, p11, p12, p13, p21, p22, p23, p31, p32, p33,
    input  morph_en, morph_data, fg_count, fg_valid
  );

  modport slave (
    input  mode, win_en, p11, p12, p13, p21, p22, p23, p31, p32, p33,
    output morph_en, morph_data, fg_count, fg_valid
  );
endinterface

// File: rtl/binary_morph_3x3_pos_cnt.sv
// Column/row position tracker for a window stream; flags frame start, border and last position.
module morph_pos_cnt
  import morph_pkg::*;
#(
  parameter logic [POS_W-1:0] CNT_COL_MAX = 16'd1023,
  parameter logic [POS_W-1:0] CNT_ROW_MAX = 16'd767
) (
  input  logic clk,
  input  logic rst_n,
  input  logic win_en,
  output logic frame_start,
  output logic border,
  output logic last_pos
);

  logic [POS_W-1:0] col_q, col_d;
  logic [POS_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (win_en) begin
      if (col_q == CNT_COL_MAX) begin
        col_d = '0;
        row_d = (row_q == CNT_ROW_MAX) ? '0 : row_q + POS_W'(1);
      end else begin
        col_d = col_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign frame_start = win_en && (col_q == '0) && (row_q == '0);
  // Left two columns hold windows that wrap across the line; top row has no row above.
  assign border      = (col_q < POS_W'(2)) || (row_q < POS_W'(1));
  assign last_pos    = (col_q == CNT_COL_MAX) && (row_q == CNT_ROW_MAX);

endmodule

// File: rtl/binary_morph_3x3.sv
// 3x3 binary erode/dilate with border forcing, fixed 2-cycle latency.
// Optional per-frame foreground count when MORPH_STATS_EN is defined.
module binary_morph_3x3
  import morph_pkg::*;
#(
  parameter logic [POS_W-1:0] CNT_COL_MAX = 16'd1023,
  parameter logic [POS_W-1:0] CNT_ROW_MAX = 16'd767,
  parameter logic             BORDER_VAL  = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  binary_morph_3x3_if.slave bus
);

  logic frame_start, border;
`ifdef MORPH_STATS_EN
  logic last_pos;
`endif

  morph_pos_cnt #(
    .CNT_COL_MAX (CNT_COL_MAX),
    .CNT_ROW_MAX (CNT_ROW_MAX)
  ) u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .win_en      (bus.win_en),
    .frame_start (frame_start),
    .border      (border),
`ifdef MORPH_STATS_EN
    .last_pos    (last_pos)
`else
    .last_pos    ()
`endif
  );

  logic mode_q, mode_d, mode_eff;
  logic [PIPE_LAT:1] vld_pipe_q, vld_pipe_d;
  s1_t  s1_q, s1_d;
  logic morph_data_q, morph_data_d;

  // The frame-start pixel already uses the newly sampled mode.
  assign mode_eff = frame_start ? bus.mode : mode_q;

  always_comb begin
    mode_d          = mode_eff;
    vld_pipe_d      = {vld_pipe_q[PIPE_LAT-1:1], bus.win_en};
    s1_d.border     = border;
    s1_d.mode       = mode_eff;
    s1_d.rows[2]    = reduce3({bus.p11, bus.p12, bus.p13}, mode_eff);
    s1_d.rows[1]    = reduce3({bus.p21, bus.p22, bus.p23}, mode_eff);
    s1_d.rows[0]    = reduce3({bus.p31, bus.p32, bus.p33}, mode_eff);
    morph_data_d    = morph_data_q;
    if (vld_pipe_q[1])
      morph_data_d = s1_q.border ? BORDER_VAL : reduce3(s1_q.rows, s1_q.mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_ERODE;
      vld_pipe_q   <= '0;
      s1_q         <= '0;
      morph_data_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      vld_pipe_q   <= vld_pipe_d;
      s1_q         <= s1_d;
      morph_data_q <= morph_data_d;
    end
  end

  assign bus.morph_en   = vld_pipe_q[PIPE_LAT];
  assign bus.morph_data = morph_data_q;

`ifdef MORPH_STATS_EN
  logic [PIPE_LAT:1]   last_pipe_q, last_pipe_d;
  logic [FG_CNT_W-1:0] acc_q, acc_d;
  logic [FG_CNT_W-1:0] fg_count_q, fg_count_d;
  logic                fg_valid_q, fg_valid_d;

  // last_pipe runs in lockstep with vld_pipe, so it is only meaningful where morph_en is high.
  always_comb begin
    last_pipe_d = {last_pipe_q[PIPE_LAT-1:1], last_pos};
    acc_d       = acc_q;
    fg_count_d  = fg_count_q;
    fg_valid_d  = 1'b0;
    if (vld_pipe_q[PIPE_LAT]) begin
      if (last_pipe_q[PIPE_LAT]) begin
        fg_count_d = acc_q + FG_CNT_W'(morph_data_q);
        fg_valid_d = 1'b1;
        acc_d      = '0;
      end else if (morph_data_q) begin
        acc_d = acc_q + FG_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pipe_q <= '0;
      acc_q       <= '0;
      fg_count_q  <= '0;
      fg_valid_q  <= 1'b0;
    end else begin
      last_pipe_q <= last_pipe_d;
      acc_q       <= acc_d;
      fg_count_q  <= fg_count_d;
      fg_valid_q  <= fg_valid_d;
    end
  end

  assign bus.fg_count = fg_count_q;
  assign bus.fg_valid = fg_valid_q;
`else
  assign bus.fg_count = '0;
  assign bus.fg_valid = 1'b0;
`endif

endmodule
